core_prf: RTL and testbench
===========================

Name: core_prf

Overview:
- Parametrised successor to the fixed 16x16 architectural register file.
- Width, depth and port counts are configurable.
- Adds a per-register pending scoreboard (reserve at issue, clear at writeback), same-cycle write-to-read bypass, deterministic write-port priority, an optional hardwired zero register, flush and a pending-count output.
- Sits between decode/issue (reserve, read) and the EX/MEM writeback lanes (write).

Parameters:
DATA_W, 16, register width in bits
DEPTH, 16, number of registers; power of two, >= 2
AW, $clog2(DEPTH), address width (derived, not overridden)
R_PORTS, 4, read ports
W_PORTS, 2, write ports
RSV_PORTS, 2, reserve (issue) ports
BYPASS, 1, 1 = read returns same-cycle write data; 0 = read returns stored data only
ZERO_REG, 0, 1 = register 0 reads 0 and ignores writes and reserves

Ports:
clk_i  in  1  clock
arst_ni  in  1  asynchronous active-low reset
r_addr_i  in  R_PORTS*AW  read addresses, port k at [k*AW +: AW]
r_data_o  out  R_PORTS*DATA_W  read data
r_rdy_o  out  R_PORTS  read operand valid (not pending, or bypassed)
w_en_i  in  W_PORTS  write enables
w_addr_i  in  W_PORTS*AW  write addresses
w_data_i  in  W_PORTS*DATA_W  write data
rsv_en_i  in  RSV_PORTS  reserve enables (mark destination pending)
rsv_addr_i  in  RSV_PORTS*AW  reserve addresses
flush_i  in  1  clear all pending bits
pend_o  out  DEPTH  pending bit per register (registered)
pend_cnt_o  out  AW+1  number of pending registers (registered)
err_o  out  1  sticky protocol error

Behaviour:
- Reset (arst_ni low, async): all registers 0; pend_o 0; pend_cnt_o 0; err_o 0. Combinational outputs then follow from zeroed state.
- Write: on posedge, mem[w_addr] <= w_data for each enabled port.
- Several enabled ports targeting the same address: highest port index wins. No OR-merge.
- Reads are combinational.
  - BYPASS=1 and an enabled write targets r_addr in the same cycle: r_data_o = winning write data and r_rdy_o = 1.
  - Otherwise: r_data_o = mem[r_addr] and r_rdy_o = ~pend[r_addr].
- Pending next state, per register, in priority order:
  1. flush_i -> 0.
  2. Any reserve to the address -> 1.
  3. Any write to the address -> 0.
  4. Otherwise hold.
- Consequence: a reserve and a write to the same register in the same cycle store the data and leave pending = 1 (the new producer owns it).
- flush_i does not block writes; data still commits.
- ZERO_REG=1, address 0:
  - r_data_o = 0 and r_rdy_o = 1 regardless of bypass.
  - Writes, reserves and errors to address 0 are ignored; pend[0] stays 0.
- pend_cnt_o is registered and equals popcount of next-state pend. It updates in the same edge as pend_o, so the two always agree. Range 0..DEPTH.
- err_o is sticky until reset. It is set on the edge after any of these:
  - (a) reserve to a register already pending, unless flush_i is high that cycle;
  - (b) two enabled reserve ports with the same address;
  - (c) write to a register not pending and not reserved in a prior cycle (pend=0 at write time).
- Error cases still apply the priority rules above; the error is informational only.
- Reset asserted mid-operation overrides everything immediately. Deassertion is assumed synchronised upstream.
- No latency beyond one edge: write-to-read without bypass is visible the cycle after the write edge.

Test Plan:
- Reset then read all DEPTH addresses -> r_data_o 0, r_rdy_o 1, pend_cnt_o 0, err_o 0.
- Reserve r5, next cycle write r5=0xBEEF via port 0 -> pend_o[5] 1 then 0; pend_cnt_o 1 then 0; read r5 with BYPASS=1 in the write cycle -> 0xBEEF, rdy 1; with BYPASS=0 -> old value, rdy 0, then 0xBEEF next cycle.
- Reserve r3, then ports 0 and 1 both write r3 (0x1111, 0x2222) -> r3 = 0x2222; r3 not pending; no error.
- Reserve r7 and write r7=0x00AA in the same cycle (r7 previously reserved) -> mem 0x00AA, pend_o[7] stays 1, pend_cnt_o unchanged.
- Reserve r1, r2, r4, then flush_i together with a reserve of r9 and a write r2=0x0042 -> all pend 0, pend_cnt_o 0, r2 = 0x0042, err_o 0.
- Error cases:
  - Reserve r6 twice in consecutive cycles -> err_o 1 and stays 1.
  - Write r8 while not pending -> err_o 1.
  - ZERO_REG=1: write r0=0xFFFF -> r0 reads 0, rdy 1, err_o unaffected.

Source files
------------

// File: rtl/core_prf.sv
// Parametrised register file with per-register pending scoreboard, write bypass,
// deterministic write-port priority, optional hardwired zero register and sticky error.
module core_prf #(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned AW        = $clog2(DEPTH),
   parameter int unsigned R_PORTS   = 4,
   parameter int unsigned W_PORTS   = 2,
   parameter int unsigned RSV_PORTS = 2,
   parameter bit          BYPASS    = 1'b1,
   parameter bit          ZERO_REG  = 1'b0
) (
   input  logic                      clk_i,
   input  logic                      arst_ni,
   input  logic [R_PORTS*AW-1:0]     r_addr_i,
   output logic [R_PORTS*DATA_W-1:0] r_data_o,
   output logic [R_PORTS-1:0]        r_rdy_o,
   input  logic [W_PORTS-1:0]        w_en_i,
   input  logic [W_PORTS*AW-1:0]     w_addr_i,
   input  logic [W_PORTS*DATA_W-1:0] w_data_i,
   input  logic [RSV_PORTS-1:0]      rsv_en_i,
   input  logic [RSV_PORTS*AW-1:0]   rsv_addr_i,
   input  logic                      flush_i,
   output logic [DEPTH-1:0]          pend_o,
   output logic [AW:0]               pend_cnt_o,
   output logic                      err_o
);

   logic [DATA_W-1:0]    mem_q [DEPTH];
   logic [DATA_W-1:0]    mem_d [DEPTH];
   logic [DEPTH-1:0]     pend_q, pend_d;
   logic [AW:0]          cnt_q, cnt_d;
   logic                 err_q, err_d;

   logic [AW-1:0]        ra  [R_PORTS];
   logic [AW-1:0]        wa  [W_PORTS];
   logic [DATA_W-1:0]    wd  [W_PORTS];
   logic [AW-1:0]        sa  [RSV_PORTS];
   logic [W_PORTS-1:0]   w_act;
   logic [RSV_PORTS-1:0] rsv_act;

   // Unpack flat port vectors; writes/reserves to a hardwired zero register are dropped here.
   always_comb begin
      w_act   = '0;
      rsv_act = '0;
      for (int unsigned k = 0; k < R_PORTS; k++)
         ra[k] = r_addr_i[k*AW +: AW];
      for (int unsigned w = 0; w < W_PORTS; w++) begin
         wa[w]    = w_addr_i[w*AW +: AW];
         wd[w]    = w_data_i[w*DATA_W +: DATA_W];
         w_act[w] = w_en_i[w] && !(ZERO_REG && wa[w] == '0);
      end
      for (int unsigned s = 0; s < RSV_PORTS; s++) begin
         sa[s]      = rsv_addr_i[s*AW +: AW];
         rsv_act[s] = rsv_en_i[s] && !(ZERO_REG && sa[s] == '0);
      end
   end

   always_comb begin
      mem_d  = mem_q;
      pend_d = pend_q;
      err_d  = err_q;
      cnt_d  = '0;
      // Ascending port order makes the highest-indexed writer win.
      for (int unsigned w = 0; w < W_PORTS; w++) begin
         if (w_act[w]) begin
            mem_d[wa[w]]  = wd[w];
            pend_d[wa[w]] = 1'b0;
            if (!pend_q[wa[w]]) err_d = 1'b1;
         end
      end
      for (int unsigned s = 0; s < RSV_PORTS; s++) begin
         if (rsv_act[s]) begin
            pend_d[sa[s]] = 1'b1;
            if (pend_q[sa[s]] && !flush_i) err_d = 1'b1;
            for (int unsigned t = s + 1; t < RSV_PORTS; t++)
               if (rsv_act[t] && sa[t] == sa[s]) err_d = 1'b1;
         end
      end
      if (flush_i) pend_d = '0;
      for (int unsigned i = 0; i < DEPTH; i++)
         cnt_d = cnt_d + {{AW{1'b0}}, pend_d[i]};
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         pend_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         mem_q  <= mem_d;
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   always_comb begin
      r_data_o = '0;
      r_rdy_o  = '0;
      for (int unsigned k = 0; k < R_PORTS; k++) begin
         r_data_o[k*DATA_W +: DATA_W] = mem_q[ra[k]];
         r_rdy_o[k]                   = !pend_q[ra[k]];
         if (BYPASS) begin
            for (int unsigned w = 0; w < W_PORTS; w++) begin
               if (w_act[w] && wa[w] == ra[k]) begin
                  r_data_o[k*DATA_W +: DATA_W] = wd[w];
                  r_rdy_o[k]                   = 1'b1;
               end
            end
         end
         if (ZERO_REG && ra[k] == '0) begin
            r_data_o[k*DATA_W +: DATA_W] = '0;
            r_rdy_o[k]                   = 1'b1;
         end
      end
   end

   assign pend_o     = pend_q;
   assign pend_cnt_o = cnt_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_core_prf.sv
// Bench for core_prf: two instances (bypass/no-zero and no-bypass/zero-reg) share
// stimulus and are checked every cycle against a behavioural model plus directed literals.
module tb_core_prf;
   localparam int unsigned DW = 16, DEP = 16, AWT = 4, RP = 4, WP = 2, SP = 2;

   logic            clk_i = 1'b0;
   logic            arst_ni;
   logic [RP*AWT-1:0] r_addr;
   logic [WP-1:0]   w_en;
   logic [WP*AWT-1:0] w_addr;
   logic [WP*DW-1:0] w_data;
   logic [SP-1:0]   rsv_en;
   logic [SP*AWT-1:0] rsv_addr;
   logic            flush;

   logic [RP*DW-1:0] rd_a, rd_b;
   logic [RP-1:0]   rdy_a, rdy_b;
   logic [DEP-1:0]  pend_a, pend_b;
   logic [AWT:0]    cnt_a, cnt_b;
   logic            err_a, err_b;

   int n_chk = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   always #5 clk_i = ~clk_i;

   core_prf #(.DATA_W(DW), .DEPTH(DEP), .R_PORTS(RP), .W_PORTS(WP), .RSV_PORTS(SP),
              .BYPASS(1'b1), .ZERO_REG(1'b0)) u_dut_a (
      .clk_i(clk_i), .arst_ni(arst_ni), .r_addr_i(r_addr), .r_data_o(rd_a), .r_rdy_o(rdy_a),
      .w_en_i(w_en), .w_addr_i(w_addr), .w_data_i(w_data), .rsv_en_i(rsv_en),
      .rsv_addr_i(rsv_addr), .flush_i(flush), .pend_o(pend_a), .pend_cnt_o(cnt_a), .err_o(err_a));

   core_prf #(.DATA_W(DW), .DEPTH(DEP), .R_PORTS(RP), .W_PORTS(WP), .RSV_PORTS(SP),
              .BYPASS(1'b0), .ZERO_REG(1'b1)) u_dut_b (
      .clk_i(clk_i), .arst_ni(arst_ni), .r_addr_i(r_addr), .r_data_o(rd_b), .r_rdy_o(rdy_b),
      .w_en_i(w_en), .w_addr_i(w_addr), .w_data_i(w_data), .rsv_en_i(rsv_en),
      .rsv_addr_i(rsv_addr), .flush_i(flush), .pend_o(pend_b), .pend_cnt_o(cnt_b), .err_o(err_b));

   // Model state, index 0 = bypass instance, 1 = zero-register instance
   logic [DW-1:0]  m_mem  [2][DEP];
   logic [DEP-1:0] m_pend [2];
   logic           m_err  [2];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int a = 0; a < DEP; a++) m_mem[m][a] = '0;
         m_pend[m] = '0;
         m_err[m]  = 1'b0;
      end
   endtask

   task automatic model_step();
      for (int m = 0; m < 2; m++) begin
         logic [DEP-1:0] np;
         bit zero;
         int a, b;
         zero = (m == 1);
         np   = m_pend[m];
         for (int r = 0; r < SP; r++) begin
            a = int'(rsv_addr[r*AWT +: AWT]);
            if (rsv_en[r] && !(zero && a == 0) && m_pend[m][a] && !flush) m_err[m] = 1'b1;
         end
         a = int'(rsv_addr[3:0]);
         b = int'(rsv_addr[7:4]);
         if (rsv_en == 2'b11 && a == b && !(zero && a == 0)) m_err[m] = 1'b1;
         for (int w = 0; w < WP; w++) begin
            a = int'(w_addr[w*AWT +: AWT]);
            if (w_en[w] && !(zero && a == 0)) begin
               if (!m_pend[m][a]) m_err[m] = 1'b1;
               m_mem[m][a] = w_data[w*DW +: DW];
               np[a] = 1'b0;
            end
         end
         for (int r = 0; r < SP; r++) begin
            a = int'(rsv_addr[r*AWT +: AWT]);
            if (rsv_en[r] && !(zero && a == 0)) np[a] = 1'b1;
         end
         if (flush) np = '0;
         m_pend[m] = np;
      end
   endtask

   task automatic exp_read(input int m, input int k, output logic [DW-1:0] d, output logic r);
      int a;
      a = int'(r_addr[k*AWT +: AWT]);
      d = m_mem[m][a];
      r = !m_pend[m][a];
      if (m == 0) begin
         for (int w = 0; w < WP; w++) begin
            if (w_en[w] && int'(w_addr[w*AWT +: AWT]) == a) begin
               d = w_data[w*DW +: DW];
               r = 1'b1;
            end
         end
      end
      if (m == 1 && a == 0) begin
         d = '0;
         r = 1'b1;
      end
   endtask

   task automatic compare_all();
      for (int m = 0; m < 2; m++) begin
         logic [RP*DW-1:0] rd;
         logic [RP-1:0]    rdy;
         logic [DW-1:0]    ed;
         logic             er;
         rd  = (m == 0) ? rd_a : rd_b;
         rdy = (m == 0) ? rdy_a : rdy_b;
         for (int k = 0; k < RP; k++) begin
            exp_read(m, k, ed, er);
            chk($sformatf("rdata%0d_%0d", m, k), 64'(rd[k*DW +: DW]), 64'(ed));
            chk($sformatf("rrdy%0d_%0d", m, k), 64'(rdy[k]), 64'(er));
         end
         chk($sformatf("pend%0d", m), 64'((m == 0) ? pend_a : pend_b), 64'(m_pend[m]));
         chk($sformatf("cnt%0d", m), 64'((m == 0) ? cnt_a : cnt_b), 64'($countones(m_pend[m])));
         chk($sformatf("err%0d", m), 64'((m == 0) ? err_a : err_b), 64'(m_err[m]));
      end
   endtask

   initial forever begin
      @(posedge clk_i or negedge arst_ni);
      if (!arst_ni) model_reset();
      else model_step();
   end

   initial forever begin
      @(negedge clk_i);
      #2;
      if (chk_on) compare_all();
   end

   task automatic idle();
      w_en   = '0;
      rsv_en = '0;
      flush  = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
      idle();
   endtask

   task automatic set_r(input int k, input int a);
      r_addr[k*AWT +: AWT] = 4'(a);
   endtask

   task automatic rsv(input int p, input int a);
      rsv_en[p] = 1'b1;
      rsv_addr[p*AWT +: AWT] = 4'(a);
   endtask

   task automatic wr(input int p, input int a, input logic [DW-1:0] d);
      w_en[p] = 1'b1;
      w_addr[p*AWT +: AWT] = 4'(a);
      w_data[p*DW +: DW] = d;
   endtask

   initial begin
      #400000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      arst_ni  = 1'b0;
      r_addr   = '0;
      w_addr   = '0;
      w_data   = '0;
      rsv_addr = '0;
      idle();
      @(negedge clk_i);
      #3;
      chk("rst_pend", 64'(pend_a), 64'h0);
      chk("rst_cnt", 64'(cnt_a), 64'h0);
      chk("rst_err_a", 64'(err_a), 64'h0);
      chk("rst_err_b", 64'(err_b), 64'h0);
      tick();
      arst_ni = 1'b1;
      chk_on  = 1'b1;

      for (int g = 0; g < 4; g++) begin
         for (int k = 0; k < RP; k++) set_r(k, g * 4 + k);
         #3;
         chk("rst_rdata", 64'(rd_a), 64'h0);
         chk("rst_rrdy", 64'(rdy_a), 64'hF);
         tick();
      end

      // reserve r5, then write 0xBEEF
      rsv(0, 5);
      tick();
      wr(0, 5, 16'hBEEF);
      set_r(0, 5);
      #3;
      chk("r5_pend", 64'(pend_a), 64'h0020);
      chk("r5_cnt", 64'(cnt_a), 64'h1);
      chk("r5_byp_data", 64'(rd_a[15:0]), 64'hBEEF);
      chk("r5_byp_rdy", 64'(rdy_a[0]), 64'h1);
      chk("r5_nobyp_data", 64'(rd_b[15:0]), 64'h0);
      chk("r5_nobyp_rdy", 64'(rdy_b[0]), 64'h0);
      tick();
      #3;
      chk("r5_after_a", 64'(rd_a[15:0]), 64'hBEEF);
      chk("r5_after_b", 64'(rd_b[15:0]), 64'hBEEF);
      chk("r5_after_rdy", 64'(rdy_b[0]), 64'h1);
      chk("r5_after_cnt", 64'(cnt_a), 64'h0);

      // two ports write r3, highest port wins
      rsv(0, 3);
      tick();
      wr(0, 3, 16'h1111);
      wr(1, 3, 16'h2222);
      set_r(1, 3);
      #3;
      chk("r3_byp", 64'(rd_a[31:16]), 64'h2222);
      tick();
      #3;
      chk("r3_data", 64'(rd_b[31:16]), 64'h2222);
      chk("r3_pend", 64'(pend_a[3]), 64'h0);
      chk("r3_err", 64'(err_a), 64'h0);

      // flush together with reserve r9 and write r2
      rsv(0, 1);
      rsv(1, 2);
      tick();
      rsv(0, 4);
      tick();
      flush = 1'b1;
      rsv(0, 9);
      wr(0, 2, 16'h0042);
      set_r(2, 2);
      #3;
      chk("fl_pend_pre", 64'(pend_a), 64'h0016);
      chk("fl_cnt_pre", 64'(cnt_a), 64'h3);
      tick();
      #3;
      chk("fl_pend", 64'(pend_b), 64'h0);
      chk("fl_cnt", 64'(cnt_a), 64'h0);
      chk("fl_r2", 64'(rd_b[47:32]), 64'h0042);
      chk("fl_err", 64'(err_a), 64'h0);

      // reserve + write r7 while r7 already pending
      rsv(0, 7);
      tick();
      rsv(0, 7);
      wr(1, 7, 16'h00AA);
      set_r(3, 7);
      #3;
      chk("r7_cnt_pre", 64'(cnt_a), 64'h1);
      tick();
      #3;
      chk("r7_data", 64'(rd_b[63:48]), 64'h00AA);
      chk("r7_pend", 64'(pend_a), 64'h0080);
      chk("r7_cnt", 64'(cnt_a), 64'h1);
      chk("r7_err", 64'(err_a), 64'h1);

      // asynchronous reset mid-operation
      arst_ni = 1'b0;
      #3;
      chk("mid_rst_pend", 64'(pend_a), 64'h0);
      chk("mid_rst_err", 64'(err_a), 64'h0);
      chk("mid_rst_r7", 64'(rd_a[63:48]), 64'h0);
      tick();
      arst_ni = 1'b1;

      // reserve r6 twice
      rsv(0, 6);
      tick();
      rsv(0, 6);
      #3;
      chk("r6_err0", 64'(err_a), 64'h0);
      tick();
      #3;
      chk("r6_err1", 64'(err_a), 64'h1);
      tick();
      #3;
      chk("r6_sticky", 64'(err_b), 64'h1);

      // write r8 while not pending
      arst_ni = 1'b0;
      tick();
      arst_ni = 1'b1;
      wr(0, 8, 16'h1234);
      #3;
      chk("r8_err0", 64'(err_a), 64'h0);
      tick();
      #3;
      chk("r8_err1", 64'(err_a), 64'h1);

      // zero register: write and reserve r0
      arst_ni = 1'b0;
      tick();
      arst_ni = 1'b1;
      wr(0, 0, 16'hFFFF);
      rsv(1, 0);
      set_r(0, 0);
      #3;
      chk("r0_b_data", 64'(rd_b[15:0]), 64'h0);
      chk("r0_b_rdy", 64'(rdy_b[0]), 64'h1);
      chk("r0_a_byp", 64'(rd_a[15:0]), 64'hFFFF);
      tick();
      #3;
      chk("r0_b_data2", 64'(rd_b[15:0]), 64'h0);
      chk("r0_b_rdy2", 64'(rdy_b[0]), 64'h1);
      chk("r0_b_pend", 64'(pend_b), 64'h0);
      chk("r0_b_err", 64'(err_b), 64'h0);
      chk("r0_a_data", 64'(rd_a[15:0]), 64'hFFFF);
      chk("r0_a_pend", 64'(pend_a), 64'h0001);
      chk("r0_a_err", 64'(err_a), 64'h1);

      // randomized traffic with narrow address range for collisions
      arst_ni = 1'b0;
      tick();
      arst_ni = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         r_addr   = 16'($urandom);
         w_en     = 2'($urandom);
         w_addr   = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
         w_data   = $urandom;
         rsv_en   = 2'($urandom);
         rsv_addr = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
         flush    = ($urandom_range(0, 15) == 0);
         arst_ni  = ($urandom_range(0, 63) != 0);
         tick();
      end
      arst_ni = 1'b1;
      tick();
      chk_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
